codec_intf: RTL and testbench

CODEC_INTF -- requirements
Module: codec_intf

---
 rtl/codec_intf.sv | 69 ++++++
 tb/tb_codec_intf.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/codec_intf.sv
// codec_intf: serial interface to an audio codec -- generates MCLK/SCLK/LRCLK from one counter,
// shifts 24-bit I2S words out on SDin and in from SDout, and releases the codec reset.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   lft_out, rht_out  signed DAC samples, sampled once per slot at the load point
//   SDout             serial ADC data from the codec
//   MCLK/SCLK/LRCLK   codec clocks: clk/4, clk/16, clk/1024 (LRCLK 0 = left slot)
//   SDin              serial DAC data to the codec, MSB first
//   RSTn              codec reset, held low for the first 1024 clocks after rst_n release
//   lft_in, rht_in    upper 16 bits of the received 24-bit ADC words
//   valid             one-clock strobe when a new lft_in/rht_in pair is available
module codec_intf (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] lft_out,
  input  logic signed [15:0] rht_out,
  input  logic               SDout,
  output logic               MCLK,
  output logic               SCLK,
  output logic               LRCLK,
  output logic               SDin,
  output logic               RSTn,
  output logic signed [15:0] lft_in,
  output logic signed [15:0] rht_in,
  output logic               valid
);
  logic [9:0]  cnt;
  logic [23:0] rx;
  logic [23:0] tx;
  logic        lft_ok;
  logic [4:0]  pos;
  logic        rx_en;
  logic        tx_ld;
  logic        tx_sh;
  assign pos   = cnt[8:4];
  assign rx_en = cnt[3:0] == 4'h8 && pos != 5'd0 && pos <= 5'd24;
  // Both slot loads land on the pos-0 SCLK fall point, so the load simply overrides the shift.
  assign tx_ld = cnt[8:0] == 9'h00F;
  assign tx_sh = cnt[3:0] == 4'hF;
  // Clocks are counter bits, i.e. flop outputs, so they cannot glitch.
  assign MCLK  = cnt[1];
  assign SCLK  = cnt[3];
  assign LRCLK = cnt[9];
  assign SDin  = tx[23];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      rx     <= '0;
      tx     <= '0;
      RSTn   <= 1'b0;
      lft_in <= '0;
      rht_in <= '0;
      lft_ok <= 1'b0;
      valid  <= 1'b0;
    end else begin
      cnt <= cnt + 10'd1;
      if (cnt == 10'h3FF) RSTn <= 1'b1;
      if (rx_en) rx <= {rx[22:0], SDout};
      if (tx_ld) tx <= {cnt[9] ? rht_out : lft_out, 8'h00};
      else if (tx_sh) tx <= {tx[22:0], 1'b0};
      if (cnt == 10'h189) begin
        lft_in <= rx[23:8];
        lft_ok <= RSTn;
      end
      if (cnt == 10'h389) rht_in <= rx[23:8];
      // a pair is only announced when both halves were received with the codec out of reset
      valid <= cnt == 10'h389 && RSTn && lft_ok;
    end
endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: scoreboard bench for codec_intf with a codec model on SDout and a DAC decoder on SDin
module tb_codec_intf;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] lft_out = 16'sh0000;
  logic signed [15:0] rht_out = 16'sh0000;
  logic               SDout = 1'b0;
  logic               MCLK, SCLK, LRCLK, SDin, RSTn, valid;
  logic signed [15:0] lft_in, rht_in;

  codec_intf dut (
    .clk(clk), .rst_n(rst_n), .lft_out(lft_out), .rht_out(rht_out), .SDout(SDout),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin), .RSTn(RSTn),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct { int ep; int fr; bit ch; logic [23:0] w; } dac_t;
  typedef struct { int ep; int fr; logic [15:0] l; logic [15:0] r; } adc_t;
  dac_t dq[$];
  adc_t aq[$];

  int checks = 0;
  int failures = 0;
  int ep = 0;
  int frm;
  logic [9:0]  tcnt;
  logic [23:0] cl = 24'hA5A5A5;
  logic [23:0] cr = 24'h123456;
  logic        lb = 1'b0;
  logic [23:0] dw = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (ep=%0d frame=%0d cnt=%h)", nm, act, exp, ep, frm, tcnt);
    end
  endtask

  task automatic push_dac(input int e, input int f, input bit c, input logic [23:0] w);
    dac_t d;
    d.ep = e; d.fr = f; d.ch = c; d.w = w;
    dq.push_back(d);
  endtask

  task automatic push_adc(input int e, input int f, input logic [15:0] l, input logic [15:0] r);
    adc_t a;
    a.ep = e; a.fr = f; a.l = l; a.r = r;
    aq.push_back(a);
  endtask

  task automatic wait_cnt(input int f, input int c);
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (frm == f && tcnt == 10'(c)) return;
    end
    failures++;
    $display("FAIL wait_cnt: frame %0d cnt %h not reached", f, c);
  endtask

  // reference frame timing: counter and frame number since the last reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      frm  <= 0;
    end else begin
      tcnt <= tcnt + 10'd1;
      if (tcnt == 10'h3FF) frm <= frm + 1;
    end

  // codec ADC model: new bit just after each SCLK fall, MSB at pos 1, LSB at pos 24
  always @(posedge clk) begin
    int p;
    logic [23:0] w;
    #1;
    p = int'(tcnt[8:4]);
    w = tcnt[9] ? cr : cl;
    SDout = lb ? SDin : ((p >= 1 && p <= 24) ? w[24 - p] : 1'b0);
  end

  // monitor: decodes SDin at each SCLK rise, checks clocks, pops scoreboard entries
  always @(negedge clk) begin
    int p;
    if (!rst_n)
      chk("reset_outputs", 64'({MCLK, SCLK, LRCLK, SDin, RSTn, valid, lft_in, rht_in}), 64'd0);
    else begin
      chk("clocks", 64'({MCLK, SCLK, LRCLK, RSTn}), 64'({tcnt[1], tcnt[3], tcnt[9], frm >= 1}));
      if (tcnt[3:0] == 4'h8) begin
        p = int'(tcnt[8:4]);
        if (p >= 1 && p <= 24) begin
          dw = {dw[22:0], SDin};
          if (p == 24 && dq.size() > 0 && dq[0].ep == ep && dq[0].fr == frm && dq[0].ch == tcnt[9]) begin
            chk(tcnt[9] ? "dac_right" : "dac_left", 64'(dw), 64'(dq[0].w));
            void'(dq.pop_front());
          end
        end else
          chk("sdin_idle", 64'(SDin), 64'd0);
      end
      if (valid) begin
        if (aq.size() > 0 && aq[0].ep == ep && aq[0].fr == frm) begin
          chk("adc_pair", 64'({lft_in, rht_in}), 64'({aq[0].l, aq[0].r}));
          void'(aq.pop_front());
        end else
          chk("valid_unexpected", 64'(valid), 64'd0);
      end
    end
  end

  initial begin
    lft_out = 16'sh8001;
    rht_out = 16'sh7FFE;
    for (int f = 0; f < 4; f++) begin
      push_dac(0, f, 1'b0, f == 3 ? 24'h5A5A00 : 24'h800100);
      push_dac(0, f, 1'b1, 24'h7FFE00);
      if (f > 0) push_adc(0, f, 16'hA5A5, 16'h1234);
    end
    push_dac(0, 4, 1'b0, 24'h5A5A00);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cnt(0, 'h1FF);
    chk("lrclk_before_512", 64'(LRCLK), 64'd0);
    @(negedge clk);
    chk("lrclk_at_512", 64'(LRCLK), 64'd1);
    wait_cnt(0, 'h3FF);
    chk("rstn_at_1023", 64'(RSTn), 64'd0);
    @(negedge clk);
    chk("rstn_at_1024", 64'(RSTn), 64'd1);
    // new left sample just after the load point must wait for the next frame
    wait_cnt(2, 'h010);
    lft_out = 16'sh5A5A;
    // reset in the middle of the left slot tail
    wait_cnt(4, 'h190);
    #2 rst_n = 1'b0;
    ep = 1;
    for (int f = 0; f < 4; f++) begin
      push_dac(1, f, 1'b0, f >= 2 ? 24'hFFFF00 : 24'h5A5A00);
      push_dac(1, f, 1'b1, f >= 2 ? 24'h000000 : 24'h7FFE00);
      if (f > 0) push_adc(1, f, f >= 2 ? 16'hFFFF : 16'hA5A5, f >= 2 ? 16'h0000 : 16'h1234);
    end
    repeat (3) @(negedge clk);
    chk("lft_in_in_reset", 64'(lft_in), 64'd0);
    #2 rst_n = 1'b1;
    wait_cnt(0, 'h3FF);
    chk("rstn_low_after_rerelease", 64'(RSTn), 64'd0);
    // loopback with extreme samples
    wait_cnt(2, 'h000);
    lft_out = 16'shFFFF;
    rht_out = 16'sh0000;
    lb = 1'b1;
    wait_cnt(4, 'h010);
    chk("dac_queue_drained", 64'(dq.size()), 64'd0);
    chk("adc_queue_drained", 64'(aq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
